// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch front end:
//               per-entry fetch exception codes, redirect source encoding,
//               the queue entry layout and the default reset PC.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package if_pkg;

   localparam logic [31:0] c_default_reset_pc = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      FEXC_NONE = 2'd0,
      FEXC_ADEL = 2'd1,
      FEXC_FERR = 2'd2
   } fetch_exc_e;

   typedef enum logic [2:0] {
      RD_NONE = 3'd0,
      RD_EXC  = 3'd1,
      RD_ERET = 3'd2,
      RD_BR   = 3'd3,
      RD_JMP  = 3'd4
   } redirect_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      fetch_exc_e  exc;
   } fetch_entry_t;

   // Fixed priority: exception > eret > branch > jump.
   function automatic redirect_e redirect_winner(input logic exc_v,
                                                 input logic eret_v,
                                                 input logic br_v,
                                                 input logic jmp_v);
      if (exc_v)       return RD_EXC;
      else if (eret_v) return RD_ERET;
      else if (br_v)   return RD_BR;
      else if (jmp_v)  return RD_JMP;
      else             return RD_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_inst_queue
// Description : DEPTH-entry circular instruction buffer. Accepts 0..FETCH_W
//               entries per cycle (written in order at the tail), pops at most
//               one entry per cycle from the head, and clears on flush.
// Ports       : clk, rst        clock / asynchronous active-high reset
//               flush           empty the queue; same-cycle push/pop ignored
//               push_cnt        number of entries of push_data to write
//               push_data       entries, element 0 first in address order
//               pop             consume the head (ignored when empty)
//               head            head entry
//               count / free    occupied / free entry counts
// Revision    : 1.0  initial release
// ============================================================================
module if_inst_queue
   import if_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int FETCH_W = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [$clog2(FETCH_W):0]        push_cnt,
   input  fetch_entry_t [FETCH_W-1:0]      push_data,
   input  logic                            pop,
   output fetch_entry_t                    head,
   output logic [$clog2(DEPTH):0]          count,
   output logic [$clog2(DEPTH):0]          free
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   fetch_entry_t        mem_q [DEPTH];
   fetch_entry_t        mem_d [DEPTH];
   logic [c_ptr_w-1:0]  head_q, head_d;
   logic [c_ptr_w-1:0]  tail_q, tail_d;
   logic [c_cnt_w-1:0]  count_q, count_d;
   logic                w_pop_ok;

   assign w_pop_ok = pop && (count_q != '0);

   always_comb begin
      logic [c_ptr_w-1:0] idx;
      idx     = '0;
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (i < int'(push_cnt)) begin
               // Pointer arithmetic wraps naturally since DEPTH is a power of two.
               idx        = tail_q + c_ptr_w'(i);
               mem_d[idx] = push_data[i];
            end
         end
         tail_d  = tail_q + c_ptr_w'(push_cnt);
         head_d  = head_q + c_ptr_w'(w_pop_ok);
         count_d = count_q + c_cnt_w'(push_cnt) - c_cnt_w'(w_pop_ok);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[head_q];
   assign count = count_q;
   assign free  = c_cnt_w'(DEPTH) - count_q;

   // The fetch credit scheme must never let the buffer overflow.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      flush || ((int'(count_q) + int'(push_cnt) - int'(w_pop_ok)) <= DEPTH));

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues
//               FETCH_W-word requests to the I-cache under a credit limit,
//               buffers responses in if_inst_queue and hands one instruction
//               per cycle to ID. Redirects flush the queue and mark in-flight
//               responses as stale.
// Ports       : clk, rst                     clock / async active-high reset
//               exc/eret/br/jmp_valid,_target redirect sources (priority order)
//               req_valid/req_ready/req_addr  I-cache request handshake
//               resp_valid/resp_data/resp_err I-cache response beat
//               id_valid/id_ready             ID handshake
//               id_pc/id_instr/id_exc         head entry toward ID
// Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter int          FETCH_W  = 2,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = c_default_reset_pc
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    exc_valid,
   input  logic [31:0]             exc_target,
   input  logic                    eret_valid,
   input  logic [31:0]             eret_target,
   input  logic                    br_valid,
   input  logic [31:0]             br_target,
   input  logic                    jmp_valid,
   input  logic [31:0]             jmp_target,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [31:0]             req_addr,
   input  logic                    resp_valid,
   input  logic [32*FETCH_W-1:0]   resp_data,
   input  logic                    resp_err,
   output logic                    id_valid,
   input  logic                    id_ready,
   output logic [31:0]             id_pc,
   output logic [31:0]             id_instr,
   output logic [1:0]              id_exc
);

   localparam int          c_cnt_w       = $clog2(DEPTH) + 1;
   localparam int          c_pn_w        = $clog2(FETCH_W) + 1;
   localparam logic [31:0] c_group_bytes = 32'(4 * FETCH_W);
   localparam logic [1:0]  c_max_out     = 2'(MAX_OUT);

   logic [31:0] fetch_pc_q, fetch_pc_d;   // next address to request
   logic [31:0] resp_pc_q, resp_pc_d;     // address of next non-stale beat
   logic [1:0]  out_q, out_d;             // accepted, unanswered requests
   logic [1:0]  drop_q, drop_d;           // stale beats still to discard
   logic        req_valid_q, req_valid_d;
   logic        adel_done_q, adel_done_d;

   redirect_e                   w_redir_sel;
   logic                        w_redir;
   logic [31:0]                 w_target;
   logic                        w_hs;
   logic                        w_resp_use;
   logic                        w_adel_push;
   logic                        w_pop;
   logic [c_pn_w-1:0]           w_push_cnt;
   fetch_entry_t [FETCH_W-1:0]  w_push_data;
   fetch_entry_t                w_head;
   logic [c_cnt_w-1:0]          w_count, w_free;
   logic [c_cnt_w-1:0]          w_count_next, w_free_next;

   always_comb begin
      w_redir_sel = redirect_winner(exc_valid, eret_valid, br_valid, jmp_valid);
      w_redir     = (w_redir_sel != RD_NONE);
      w_target    = jmp_target;
      case (w_redir_sel)
         RD_EXC:  w_target = exc_target;
         RD_ERET: w_target = eret_target;
         RD_BR:   w_target = br_target;
         default: w_target = jmp_target;
      endcase
   end

   assign w_hs       = req_valid_q && req_ready;
   assign w_resp_use = resp_valid && !w_redir && (drop_q == 2'd0);
   assign w_pop      = id_valid && id_ready;

   // A misaligned PC reports AdEL once the pipe holds no older responses.
   assign w_adel_push = !w_redir && (fetch_pc_q[1:0] != 2'b00) && (out_q == 2'd0) &&
                        (drop_q == 2'd0) && !adel_done_q && (w_free != '0) && !resp_valid;

   assign w_push_cnt = w_resp_use  ? c_pn_w'(FETCH_W) :
                       w_adel_push ? c_pn_w'(1) : '0;

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         w_push_data[i].pc    = resp_pc_q + 32'(4 * i);
         w_push_data[i].instr = resp_data[32*i +: 32];
         w_push_data[i].exc   = resp_err ? FEXC_FERR : FEXC_NONE;
      end
      if (w_adel_push) begin
         w_push_data[0].pc    = fetch_pc_q;
         w_push_data[0].instr = '0;
         w_push_data[0].exc   = FEXC_ADEL;
      end
   end

   // Occupancy after this edge, used to grant credit for the next request.
   assign w_count_next = w_redir ? '0 : (w_count + c_cnt_w'(w_push_cnt) - c_cnt_w'(w_pop));
   assign w_free_next  = c_cnt_w'(DEPTH) - w_count_next;

   always_comb begin
      out_d = out_q + 2'(w_hs) - 2'(resp_valid);
      if (w_redir) begin
         // Everything still in flight (including a request accepted right
         // now) belongs to the old stream.
         fetch_pc_d  = w_target;
         resp_pc_d   = w_target;
         drop_d      = out_d;
         adel_done_d = 1'b0;
      end else begin
         fetch_pc_d  = w_hs ? (fetch_pc_q + c_group_bytes) : fetch_pc_q;
         resp_pc_d   = w_resp_use ? (resp_pc_q + c_group_bytes) : resp_pc_q;
         drop_d      = (resp_valid && (drop_q != 2'd0)) ? (drop_q - 2'd1) : drop_q;
         adel_done_d = adel_done_q | w_adel_push;
      end
      // Reserve FETCH_W slots for every outstanding request plus the new one.
      req_valid_d = (fetch_pc_d[1:0] == 2'b00) && (out_d < c_max_out) &&
                    (int'(w_free_next) >= FETCH_W * (int'(out_d) + 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         resp_pc_q   <= RESET_PC;
         out_q       <= 2'd0;
         drop_q      <= 2'd0;
         req_valid_q <= 1'b0;
         adel_done_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         resp_pc_q   <= resp_pc_d;
         out_q       <= out_d;
         drop_q      <= drop_d;
         req_valid_q <= req_valid_d;
         adel_done_q <= adel_done_d;
      end
   end

   if_inst_queue #(
      .DEPTH   (DEPTH),
      .FETCH_W (FETCH_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (w_redir),
      .push_cnt  (w_push_cnt),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count),
      .free      (w_free)
   );

   assign req_valid = req_valid_q;
   assign req_addr  = fetch_pc_q;
   assign id_valid  = (w_count != '0);
   assign id_pc     = w_head.pc;
   assign id_instr  = w_head.instr;
   assign id_exc    = w_head.exc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit with an in-order I-cache
//               model of programmable latency and an expected-entry queue for
//               the ID side.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;
   import if_pkg::*;

   localparam int          DEPTH   = 8;
   localparam int          FETCH_W = 2;
   localparam int          MAX_OUT = 2;
   localparam logic [31:0] RST_PC  = 32'hBFC0_0000;

   logic                  clk, rst;
   logic                  exc_valid, eret_valid, br_valid, jmp_valid;
   logic [31:0]           exc_target, eret_target, br_target, jmp_target;
   logic                  req_valid, req_ready;
   logic [31:0]           req_addr;
   logic                  resp_valid, resp_err;
   logic [32*FETCH_W-1:0] resp_data;
   logic                  id_valid, id_ready;
   logic [31:0]           id_pc, id_instr;
   logic [1:0]            id_exc;

   if_fetch_unit #(
      .DEPTH(DEPTH), .FETCH_W(FETCH_W), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_target(exc_target),
      .eret_valid(eret_valid), .eret_target(eret_target),
      .br_valid(br_valid), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_instr(id_instr), .id_exc(id_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] instr; logic [1:0] exc; } exp_t;
   typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;

   exp_t        sb[$];     // entries ID must see, in order
   pend_t       pend[$];   // requests accepted by the cache model
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          lat = 1;
   logic [31:0] exp_req_addr = RST_PC;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   bit          gap_on = 1'b0;
   bit          mis_on = 1'b0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(negedge clk);
      cyc++;
      exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
   endtask

   // One cycle of cache model and ID-side checking, using the inputs already
   // driven for the upcoming rising edge.
   task automatic eval();
      logic        redir;
      logic [31:0] tgt;
      exp_t        e;
      pend_t       p;
      redir = exc_valid | eret_valid | br_valid | jmp_valid;
      tgt   = exc_valid ? exc_target : eret_valid ? eret_target :
              br_valid ? br_target : jmp_target;

      if (gap_on && sb.size() > 0) chk("no_gap", 64'(id_valid), 64'd1);
      if (mis_on) chk("adel_no_req", 64'(req_valid), 64'd0);
      if (id_valid && id_ready && !redir) begin
         if (sb.size() == 0) chk("id_spurious", 64'(id_valid), 64'd0);
         else begin
            e = sb.pop_front();
            chk("id_pc", 64'(id_pc), 64'(e.pc));
            chk("id_instr", 64'(id_instr), 64'(e.instr));
            chk("id_exc", 64'(id_exc), 64'(e.exc));
         end
      end

      resp_valid = 1'b0; resp_err = 1'b0; resp_data = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         resp_valid = 1'b1;
         resp_err   = (p.addr == err_addr);
         for (int i = 0; i < FETCH_W; i++) begin
            resp_data[32*i +: 32] = word_of(p.addr + 32'(4*i));
            if (!redir && p.epoch == epoch)
               sb.push_back('{pc: p.addr + 32'(4*i), instr: word_of(p.addr + 32'(4*i)),
                              exc: (resp_err ? 2'd2 : 2'd0)});
         end
      end

      if (req_valid && req_ready) begin
         chk("req_addr", 64'(req_addr), 64'(exp_req_addr));
         pend.push_back('{addr: req_addr, epoch: epoch, due: cyc + lat});
         exp_req_addr = exp_req_addr + 32'(4*FETCH_W);
      end

      if (redir) begin
         epoch++;
         sb.delete();
         exp_req_addr = tgt;
         mis_on = (tgt[1:0] != 2'b00);
         if (mis_on) sb.push_back('{pc: tgt, instr: 32'h0, exc: 2'd1});
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin next(); eval(); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1;
      exc_valid = 0; eret_valid = 0; br_valid = 0; jmp_valid = 0;
      exc_target = '0; eret_target = '0; br_target = '0; jmp_target = '0;
      req_ready = 1'b1; id_ready = 1'b0;
      resp_valid = 1'b0; resp_err = 1'b0; resp_data = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_id_instr", 64'(id_instr), 64'd0);
      chk("rst_id_exc", 64'(id_exc), 64'd0);

      // Free run: one-cycle cache, ID always ready
      rst = 1'b0; id_ready = 1'b1; gap_on = 1'b1;
      chk("c0_req_valid", 64'(req_valid), 64'd0);
      eval();
      next();
      chk("first_req_valid", 64'(req_valid), 64'd1);
      chk("first_req_addr", 64'(req_addr), 64'(RST_PC));
      eval();
      run(30);

      // Backpressure from an empty queue: fills to DEPTH, requests stop
      next();
      gap_on = 1'b0; id_ready = 1'b0;
      jmp_valid = 1'b1; jmp_target = 32'h8000_2000;
      eval();
      run(25);
      chk("bp_fill", 64'(sb.size()), 64'(DEPTH));
      chk("bp_req_stall", 64'(req_valid), 64'd0);
      chk("bp_id_valid", 64'(id_valid), 64'd1);
      next();
      id_ready = 1'b1; gap_on = 1'b1;
      eval();
      run(20);

      // Branch redirect with two requests in flight
      gap_on = 1'b0; lat = 3;
      k = 0;
      next();
      while (pend.size() < 2 && k < 30) begin eval(); next(); k++; end
      chk("two_outstanding", 64'(pend.size() >= 2), 64'd1);
      br_valid = 1'b1; br_target = 32'h8000_1000;
      eval();
      next();
      chk("br_req_addr", 64'(req_addr), 64'h8000_1000);
      chk("br_q_empty", 64'(id_valid), 64'd0);
      eval();
      run(15);

      // Simultaneous redirects: exception wins
      lat = 1;
      run(3);
      next();
      exc_valid = 1'b1; exc_target = 32'h8000_3000;
      br_valid  = 1'b1; br_target  = 32'h8000_4000;
      jmp_valid = 1'b1; jmp_target = 32'h8000_5000;
      eval();
      next();
      chk("multi_q_empty", 64'(id_valid), 64'd0);
      chk("multi_req_addr", 64'(req_addr), 64'h8000_3000);
      eval();
      run(10);

      // Misaligned jump target: single AdEL entry, then stall
      next();
      jmp_valid = 1'b1; jmp_target = 32'h8000_0002;
      eval();
      run(12);
      chk("adel_drained", 64'(sb.size()), 64'd0);
      chk("adel_stall_idv", 64'(id_valid), 64'd0);
      chk("adel_stall_req", 64'(req_valid), 64'd0);

      // Fetch error on the group at 80000010, then reset mid-drain
      next();
      err_addr = 32'h8000_0010;
      eret_valid = 1'b1; eret_target = 32'h8000_0010;
      eval();
      run(3);
      next();
      chk("err_id_pc", 64'(id_pc), 64'h8000_0014);
      chk("err_id_exc", 64'(id_exc), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_idv", 64'(id_valid), 64'd0);
      chk("rst_async_req", 64'(req_valid), 64'd0);
      resp_valid = 1'b0; resp_err = 1'b0; resp_data = '0;
      pend.delete(); sb.delete(); epoch++;
      exp_req_addr = RST_PC; mis_on = 1'b0; gap_on = 1'b0;
      err_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; gap_on = 1'b1;
      eval();
      next();
      chk("restart_req_valid", 64'(req_valid), 64'd1);
      chk("restart_req_addr", 64'(req_addr), 64'(RST_PC));
      eval();
      run(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
